timer_share_arbiter: RTL and testbench
======================================

Name: timer_share_arbiter

Overview:
- Shares one WIDTH-bit up-counter between two requesters, each asking for a timed interval of a given length.
- Arbitrates round-robin and runs the counter for the granted requester.
- Pulses that requester's done when the interval completes, then returns the counter to idle.
- Sits between requesting control logic and the counter; q is exported so benches can $monitor it.

Parameters:
WIDTH, 4, width of the shared counter and of the length inputs.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
req  input  2  req[i] high = requester i wants the timer; held until done[i] or dropped to abort.
len0  input  WIDTH  interval length for requester 0, sampled at grant.
len1  input  WIDTH  interval length for requester 1, sampled at grant.
gnt  output  2  one-hot grant, registered; high while the timer runs for that requester.
done  output  2  one-cycle completion pulse for the requester that finished.
busy  output  1  high in any state other than IDLE.
q  output  WIDTH  current shared counter value.

Behaviour:
- States: IDLE, RUN, DONE, all registered. While reset is low: state=IDLE, gnt=0, done=0, busy=0, q=0, round-robin pointer ptr=0, latched length len_l=0.
- Reset low in mid-RUN clears everything immediately. No done pulse is issued.
- IDLE, no req: stay in IDLE; q holds 0.
- IDLE, any req: at the next edge go to RUN.
  - Winner: requester ptr if req[ptr], else the other requester.
  - gnt[winner]=1, len_l = len of winner, q=0, busy=1.
  - ptr = ~winner, so the last-served requester has lowest priority.
- RUN, req[winner] still high:
  - If q == len_l: go to DONE, gnt=0, done[winner]=1.
  - Otherwise q = q+1.
  - Length L therefore gives gnt high for exactly L+1 cycles, with q running 0..L.
  - L=0 gives one RUN cycle, then DONE.
- RUN, req[winner] low (abort): go to IDLE at the next edge, gnt=0, q=0, no done. ptr keeps its updated value.
- DONE: done high for exactly one cycle, busy=1. Next edge: IDLE, done=0, q=0.
  - Earliest next grant is one cycle after leaving DONE; there is always one IDLE cycle between intervals.
- Width rules:
  - q never wraps: maximum L = 2^WIDTH-1 (15), and the compare fires at q=15 before any increment.
  - len changes while granted are ignored, because len_l is latched at grant.
- Simultaneous requests: both req high in IDLE grants requester ptr. A request raised by the loser during RUN waits and is served next.
- A requester whose req is high in IDLE is always granted within one interval plus two cycles (no starvation).
- done and gnt are never high together; gnt is never non-one-hot.

Optional Feature:
- Macro: TIMER_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, requester 0 always wins simultaneous requests and ptr is unused (held at 0).
- Undefined (default): round-robin as described above.

Test Plan:
- Reset held low 15 ns, then req=01, len0=3 → gnt=01 for 4 cycles with q=0,1,2,3, then done=01 for 1 cycle, busy low the cycle after.
- req=11 from reset release, len0=2, len1=5, both held until their own done:
  - Requester 0 is granted first; after its done and one IDLE cycle, requester 1 is granted for 6 cycles with q reaching 5.
  - ptr ends at 0.
- req=01, len0=0 → gnt=01 for 1 cycle with q=0, then done=01 next cycle.
- req=10, len1=15 → q counts 0..15 with no wrap, done=10 after 16 grant cycles.
- Abort: req=01, len0=10, drop req[0] when q=4 → next edge gnt=00, q=0, done never pulses, busy=0.
- Reset mid-RUN: req=10, len1=8, pull reset low at q=5 → outputs zero immediately; on release with req=11, requester 0 wins because ptr was cleared to 0. With TIMER_ARB_FIXED_PRIO_EN defined, repeated req=11 always grants requester 0.

Source files
------------

// File: rtl/timer_share_arbiter.sv
// timer_share_arbiter
//   Shares one WIDTH-bit up-counter between two requesters. Arbitration is
//   round-robin by default. The counter then runs from 0 up to the granted
//   requester's latched length. When it gets there, the arbiter pulses that
//   requester's done for one cycle and returns to IDLE.
//
//   Optional feature: define TIMER_ARB_FIXED_PRIO_EN to select fixed priority.
//   In that mode requester 0 always wins simultaneous requests, and the
//   round-robin pointer is held at 0.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   req    in   [1:0] per-requester timer request (drop while granted = abort)
//   len0   in   [WIDTH-1:0] interval length of requester 0, sampled at grant
//   len1   in   [WIDTH-1:0] interval length of requester 1, sampled at grant
//   gnt    out  [1:0] registered one-hot grant, high while counting
//   done   out  [1:0] one-cycle completion pulse
//   busy   out  high whenever not IDLE
//   q      out  [WIDTH-1:0] shared counter value
module timer_share_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [WIDTH-1:0] q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             ptr_q, ptr_d;
  logic             win_q, win_d;   // index of the requester being timed
  logic             nxt_win;

  // Pick the winner for a grant taken from IDLE.
  always_comb begin
`ifdef TIMER_ARB_FIXED_PRIO_EN
    nxt_win = ~req[0];
`else
    nxt_win = req[ptr_q] ? ptr_q : ~ptr_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    q_d     = q_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        gnt_d = 2'b00;
        q_d   = '0;
        if (|req) begin
          state_d = RUN;
          win_d   = nxt_win;
          gnt_d   = nxt_win ? 2'b10 : 2'b01;
          len_d   = nxt_win ? len1 : len0;
`ifdef TIMER_ARB_FIXED_PRIO_EN
          ptr_d   = 1'b0;
`else
          // The requester just served drops to lowest priority.
          ptr_d   = ~nxt_win;
`endif
        end
      end
      RUN: begin
        if (!req[win_q]) begin
          // Abort: the pointer keeps the value it took at grant.
          state_d = IDLE;
          gnt_d   = 2'b00;
          q_d     = '0;
        end else if (q_q == len_q) begin
          // The compare is checked before the increment, so q never wraps.
          state_d = DONE;
          gnt_d   = 2'b00;
          done_d  = win_q ? 2'b10 : 2'b01;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        q_d     = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        q_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      q_q     <= '0;
      len_q   <= '0;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      q_q     <= q_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign q    = q_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_timer_share_arbiter.sv
module tb_timer_share_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [3:0] len0 = 4'd0;
  logic [3:0] len1 = 4'd0;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic [3:0] q;

  int checks = 0;
  int errors = 0;

  timer_share_arbiter #(.WIDTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .len0 (len0),
    .len1 (len1),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .q    (q)
  );

  always #5 clk = ~clk;

  // The grant must stay one-hot, and done must never overlap with a grant.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ((gnt != 2'b00 && done != 2'b00) || gnt == 2'b11 || done == 2'b11) begin
        errors++;
        $display("FAIL invariant: gnt=%b done=%b", gnt, done);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset low, then release it at a negedge with the given inputs applied.
  task automatic apply_reset(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1);
    @(negedge clk);
    reset = 1'b0;
    req   = 2'b00;
    repeat (2) @(negedge clk);
    req   = r;
    len0  = l0;
    len1  = l1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    req = 2'b01; len0 = 4'd3;
    #1 reset = 1'b0;
    #3;
    checks++;
    if ({gnt, done, busy, q} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b done=%b busy=%b q=%0d, want all 0", gnt, done, busy, q);
    end
    #12;   // reset has been low for about 15 ns
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    // Continues directly from test_reset: req=01, len0=3.
    for (int k = 0; k <= 3; k++) begin
      tick();
      checks++;
      if ({gnt, done, busy, q} !== {2'b01, 2'b00, 1'b1, 4'(k)}) begin
        errors++;
        $display("FAIL single_run k=%0d: got gnt=%b done=%b busy=%b q=%0d", k, gnt, done, busy, q);
      end
    end
    tick();
    checks++;
    if ({gnt, done, busy} !== {2'b00, 2'b01, 1'b1}) begin
      errors++;
      $display("FAIL single_done: got gnt=%b done=%b busy=%b, want 00 01 1", gnt, done, busy);
    end
    req = 2'b00;
    tick();
    checks++;
    if ({gnt, done, busy, q} !== 9'b0) begin
      errors++;
      $display("FAIL single_idle: got gnt=%b done=%b busy=%b q=%0d", gnt, done, busy, q);
    end
  endtask

  task automatic test_both();
    apply_reset(2'b11, 4'd2, 4'd5);
    for (int k = 0; k <= 2; k++) begin
      tick();
      checks++;
      if ({gnt, q} !== {2'b01, 4'(k)}) begin
        errors++;
        $display("FAIL both_r0 k=%0d: got gnt=%b q=%0d", k, gnt, q);
      end
    end
    tick();
    checks++;
    if ({gnt, done} !== {2'b00, 2'b01}) begin
      errors++;
      $display("FAIL both_done0: got gnt=%b done=%b, want 00 01", gnt, done);
    end
    req = 2'b10;
    tick();
    checks++;
    if ({gnt, done, busy} !== 5'b0) begin
      errors++;
      $display("FAIL both_gap: got gnt=%b done=%b busy=%b, want idle", gnt, done, busy);
    end
    for (int k = 0; k <= 5; k++) begin
      tick();
      checks++;
      if ({gnt, q} !== {2'b10, 4'(k)}) begin
        errors++;
        $display("FAIL both_r1 k=%0d: got gnt=%b q=%0d", k, gnt, q);
      end
    end
    tick();
    checks++;
    if ({gnt, done} !== {2'b00, 2'b10}) begin
      errors++;
      $display("FAIL both_done1: got gnt=%b done=%b, want 00 10", gnt, done);
    end
    // Requester 1 was served last, so the pointer is back at requester 0.
    req = 2'b11;
    tick();
    tick();
    checks++;
    if (gnt !== 2'b01) begin
      errors++;
      $display("FAIL both_ptr0: got gnt=%b, want 01", gnt);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_len_zero();
    apply_reset(2'b01, 4'd0, 4'd0);
    tick();
    checks++;
    if ({gnt, done, q} !== {2'b01, 2'b00, 4'd0}) begin
      errors++;
      $display("FAIL len0_run: got gnt=%b done=%b q=%0d", gnt, done, q);
    end
    tick();
    checks++;
    if ({gnt, done} !== {2'b00, 2'b01}) begin
      errors++;
      $display("FAIL len0_done: got gnt=%b done=%b, want 00 01", gnt, done);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_max_len();
    apply_reset(2'b10, 4'd0, 4'd15);
    for (int k = 0; k <= 15; k++) begin
      tick();
      checks++;
      if ({gnt, done, q} !== {2'b10, 2'b00, 4'(k)}) begin
        errors++;
        $display("FAIL max_run k=%0d: got gnt=%b done=%b q=%0d", k, gnt, done, q);
      end
      if (k == 5) len1 = 4'd2;   // must be ignored: the length is latched at grant
    end
    tick();
    checks++;
    if ({gnt, done} !== {2'b00, 2'b10}) begin
      errors++;
      $display("FAIL max_done: got gnt=%b done=%b, want 00 10", gnt, done);
    end
    req = 2'b00;
    tick();
    checks++;
    if ({busy, q} !== 5'b0) begin
      errors++;
      $display("FAIL max_idle: got busy=%b q=%0d", busy, q);
    end
  endtask

  task automatic test_abort();
    apply_reset(2'b01, 4'd10, 4'd0);
    for (int k = 0; k <= 4; k++) tick();
    checks++;
    if ({gnt, q} !== {2'b01, 4'd4}) begin
      errors++;
      $display("FAIL abort_pre: got gnt=%b q=%0d, want 01 4", gnt, q);
    end
    req = 2'b00;
    tick();
    checks++;
    if ({gnt, done, busy, q} !== 9'b0) begin
      errors++;
      $display("FAIL abort_idle: got gnt=%b done=%b busy=%b q=%0d", gnt, done, busy, q);
    end
    tick();
    checks++;
    if (done !== 2'b00) begin
      errors++;
      $display("FAIL abort_nodone: got done=%b, want 00", done);
    end
  endtask

  task automatic test_rr_alternate();
    logic [1:0] exp_g;
`ifdef TIMER_ARB_FIXED_PRIO_EN
    exp_g = 2'b01;
`else
    exp_g = 2'b10;
`endif
    apply_reset(2'b01, 4'd1, 4'd1);
    tick(); tick(); tick();   // q=0, q=1, then DONE
    checks++;
    if (done !== 2'b01) begin
      errors++;
      $display("FAIL rr_done0: got done=%b, want 01", done);
    end
    req = 2'b11;
    tick();   // mandatory IDLE cycle
    tick();
    checks++;
    if (gnt !== exp_g) begin
      errors++;
      $display("FAIL rr_second: got gnt=%b, want %b", gnt, exp_g);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_run();
    apply_reset(2'b10, 4'd0, 4'd8);
    for (int k = 0; k <= 5; k++) tick();
    checks++;
    if ({gnt, q} !== {2'b10, 4'd5}) begin
      errors++;
      $display("FAIL midrst_pre: got gnt=%b q=%0d, want 10 5", gnt, q);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({gnt, done, busy, q} !== 9'b0) begin
      errors++;
      $display("FAIL midrst_clear: got gnt=%b done=%b busy=%b q=%0d", gnt, done, busy, q);
    end
    @(negedge clk);
    req = 2'b11;
    reset = 1'b1;
    tick();
    checks++;
    if ({gnt, q} !== {2'b01, 4'd0}) begin
      errors++;
      $display("FAIL midrst_regrant: got gnt=%b q=%0d, want 01 0", gnt, q);
    end
    req = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_len_zero();
    test_max_len();
    test_abort();
    test_rr_alternate();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
